// File: rtl/haz_pkg.sv
// Shared constants, shadow-stage record and register-match helper for the
// hazard request generator.
package haz_pkg;

  localparam int REQ_DATA = 7;
  localparam int REQ_STR  = 6;
  localparam int REQ_CTRL = 4;
  localparam int REQ_FWRD = 3;
  localparam int REQ_CRCT = 2;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_EX   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  // Widest register index a shadow stage can hold; narrower indices are zero-extended.
  localparam int RD_W = 8;

  typedef struct packed {
    logic            vld;
    logic [RD_W-1:0] rd;
    logic            load;
    logic            branch;
    logic            pred;
  } shadow_t;

  localparam shadow_t SHADOW_BUBBLE = '0;

  // r0 is hardwired, so a write to it can never create a dependency.
  function automatic logic reg_match(input shadow_t s, input logic [RD_W-1:0] idx);
    return s.vld && (s.rd == idx) && (idx != '0);
  endfunction

endpackage

// File: rtl/haz_shadow_stage.sv
// One shadow pipeline register: captures the incoming record when take is
// high, otherwise inserts a bubble.
module haz_shadow_stage
  import haz_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    take,
  input  shadow_t d,
  output shadow_t q
);

  always_ff @(posedge clk) begin
    if (rst)       q <= SHADOW_BUBBLE;
    else if (take) q <= d;
    else           q <= SHADOW_BUBBLE;
  end

endmodule

// File: rtl/haz_req_gen.sv
// Request side of the hazard resolver: shadows EX/MEM, compares against ID and
// emits the registered request vector, forward selects and a stall watchdog.
module haz_req_gen
  import haz_pkg::*;
#(
  parameter int RW        = 5,
  parameter int STALL_MAX = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_vld,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic [RW-1:0] id_rd,
  input  logic          id_load,
  input  logic          id_store,
  input  logic          id_branch,
  input  logic          id_br_pred,
  input  logic          ex_br_taken,
  input  logic          resolved,
  input  logic          pc_freeze,
  input  logic          do_flush,
  output logic [7:0]    req_vec,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          issue,
  output logic          stall_err
);

  localparam int WDW = $clog2(STALL_MAX + 1);
  localparam logic [WDW-1:0] WD_MAX = WDW'(STALL_MAX);

  shadow_t ex_q, mem_q, id_s;
  logic [RD_W-1:0] rs1_x, rs2_x;
  logic [7:0] req_next;
  logic m1_ex, m1_mem, m2_ex, m2_mem;
  logic lu1, lu2, fw1, fw2, lu_any, str_only;
  logic data_c, fwrd_c, ctrl_c, crct_c;
  logic [WDW-1:0] wd_cnt;

  // A flush outranks a freeze: either way nothing enters EX.
  assign issue = id_vld & ~pc_freeze & ~do_flush;
  assign rs1_x = RD_W'(id_rs1);
  assign rs2_x = RD_W'(id_rs2);

  always_comb begin
    id_s        = SHADOW_BUBBLE;
    id_s.vld    = 1'b1;
    id_s.rd     = RD_W'(id_rd);
    id_s.load   = id_load;
    id_s.branch = id_branch;
    id_s.pred   = id_br_pred;
  end

  haz_shadow_stage u_ex (
    .clk  (clk),
    .rst  (rst),
    .take (issue),
    .d    (id_s),
    .q    (ex_q)
  );

  haz_shadow_stage u_mem (
    .clk  (clk),
    .rst  (rst),
    .take (1'b1),
    .d    (ex_q),
    .q    (mem_q)
  );

  always_comb begin
    m1_ex  = id_vld & reg_match(ex_q,  rs1_x);
    m1_mem = id_vld & reg_match(mem_q, rs1_x);
    m2_ex  = id_vld & reg_match(ex_q,  rs2_x);
    m2_mem = id_vld & reg_match(mem_q, rs2_x);
    lu1    = m1_ex & ex_q.load;
    lu2    = m2_ex & ex_q.load;
    fw1    = (m1_ex | m1_mem) & ~lu1;
    fw2    = (m2_ex | m2_mem) & ~lu2;
    lu_any = lu1 | lu2;
    // Store data alone waiting on a load is a store hazard, not a data stall.
    str_only = id_store & lu2 & ~lu1;
    data_c   = (lu_any & ~str_only) | fw1 | fw2;
    fwrd_c   = (fw1 | fw2) & ~lu_any;
    ctrl_c   = ex_q.vld & ex_q.branch;
    crct_c   = ctrl_c & (ex_br_taken == ex_q.pred);

    fwd_a = lu1 ? FWD_NONE : m1_ex ? FWD_EX : m1_mem ? FWD_MEM : FWD_NONE;
    fwd_b = lu2 ? FWD_NONE : m2_ex ? FWD_EX : m2_mem ? FWD_MEM : FWD_NONE;

    req_next           = '0;
    req_next[REQ_DATA] = data_c;
    req_next[REQ_STR]  = str_only;
    req_next[REQ_CTRL] = ctrl_c;
    req_next[REQ_FWRD] = fwrd_c;
    req_next[REQ_CRCT] = crct_c;
  end

  always_ff @(posedge clk) begin
    if (rst) req_vec <= '0;
    else     req_vec <= req_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt    <= '0;
      stall_err <= 1'b0;
    end else if (pc_freeze & ~resolved) begin
      if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + WDW'(1);
      if (wd_cnt >= WD_MAX - WDW'(1)) stall_err <= 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_haz_req_gen.sv
// Bench for haz_req_gen: directed scenarios with literal expectations, then
// randomized traffic against an instruction-level reference model.
module tb_haz_req_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_vld = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_load = 1'b0, id_store = 1'b0, id_branch = 1'b0, id_br_pred = 1'b0;
  logic       ex_br_taken = 1'b0, resolved = 1'b0, pc_freeze = 1'b0, do_flush = 1'b0;
  logic [7:0] req_vec;
  logic [1:0] fwd_a, fwd_b;
  logic       issue, stall_err;

  always #5 clk = ~clk;

  haz_req_gen #(.RW(5), .STALL_MAX(15)) dut (
    .clk(clk), .rst(rst), .id_vld(id_vld), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_load(id_load), .id_store(id_store), .id_branch(id_branch),
    .id_br_pred(id_br_pred), .ex_br_taken(ex_br_taken), .resolved(resolved),
    .pc_freeze(pc_freeze), .do_flush(do_flush), .req_vec(req_vec),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .issue(issue), .stall_err(stall_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the two instructions in flight, youngest first.
  typedef struct {bit vld; int rd; bit ld; bit br; bit pr;} ent_t;
  ent_t pipe[2];
  logic [1:0] m_fa, m_fb;
  logic       m_iss;
  logic [7:0] m_nreq;
  logic [7:0] exp_req = '0;
  logic       exp_err = 1'b0;
  int         wd = 0;

  function automatic int producer(int r);
    if (r == 0) return -1;
    for (int k = 0; k < 2; k++)
      if (pipe[k].vld && pipe[k].rd == r) return k;
    return -1;
  endfunction

  function automatic void model_eval();
    int p1, p2;
    bit lu1, lu2, f1, f2, so, dat, fw, ctl, crc;
    p1  = id_vld ? producer(int'(id_rs1)) : -1;
    p2  = id_vld ? producer(int'(id_rs2)) : -1;
    lu1 = (p1 == 0) && pipe[0].ld;
    lu2 = (p2 == 0) && pipe[0].ld;
    f1  = (p1 >= 0) && !lu1;
    f2  = (p2 >= 0) && !lu2;
    so  = id_store && lu2 && !lu1;
    dat = ((lu1 || lu2) && !so) || f1 || f2;
    fw  = (f1 || f2) && !(lu1 || lu2);
    ctl = pipe[0].vld && pipe[0].br;
    crc = ctl && (ex_br_taken == pipe[0].pr);
    m_fa   = lu1 ? 2'd0 : (p1 == 0) ? 2'd1 : (p1 == 1) ? 2'd2 : 2'd0;
    m_fb   = lu2 ? 2'd0 : (p2 == 0) ? 2'd1 : (p2 == 1) ? 2'd2 : 2'd0;
    m_iss  = id_vld && !pc_freeze && !do_flush;
    m_nreq = 8'(dat * 128 + so * 64 + ctl * 16 + fw * 8 + crc * 4);
  endfunction

  task automatic model_step();
    if (rst) begin
      pipe[0] = '{default: 0};
      pipe[1] = '{default: 0};
      exp_req = '0;
      wd      = 0;
      exp_err = 1'b0;
    end else begin
      pipe[1] = pipe[0];
      if (m_iss) pipe[0] = '{vld: 1, rd: int'(id_rd), ld: id_load, br: id_branch, pr: id_br_pred};
      else       pipe[0] = '{default: 0};
      exp_req = m_nreq;
      if (pc_freeze && !resolved) begin
        if (wd < 15) wd++;
        if (wd == 15) exp_err = 1'b1;
      end else begin
        wd = 0;
      end
    end
  endtask

  // Advance one clock; returns 1 time unit after the edge.
  task automatic cycle();
    model_eval();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic set_id(input bit v, input int r1, input int r2, input int rd,
                        input bit ld, input bit st, input bit br, input bit pr);
    id_vld = v; id_rs1 = 5'(r1); id_rs2 = 5'(r2); id_rd = 5'(rd);
    id_load = ld; id_store = st; id_branch = br; id_br_pred = pr;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    repeat (3) cycle();
    rst = 1'b0;
    #1;
    n_cmp++; if (req_vec !== 8'h00) begin n_bad++; $display("FAIL rst_req got=%b want=%b", req_vec, 8'h00); end
    n_cmp++; if (fwd_a !== 2'b00) begin n_bad++; $display("FAIL rst_fwd_a got=%b want=00", fwd_a); end
    n_cmp++; if (fwd_b !== 2'b00) begin n_bad++; $display("FAIL rst_fwd_b got=%b want=00", fwd_b); end
    n_cmp++; if (stall_err !== 1'b0) begin n_bad++; $display("FAIL rst_err got=%b want=0", stall_err); end
    n_cmp++; if (issue !== 1'b0) begin n_bad++; $display("FAIL rst_issue got=%b want=0", issue); end
    cycle();
    n_cmp++; if (req_vec !== 8'h00) begin n_bad++; $display("FAIL idle_req got=%b want=%b", req_vec, 8'h00); end
  endtask

  task automatic test_load_use();
    set_id(1, 1, 2, 5, 1, 0, 0, 0);
    cycle();
    set_id(1, 5, 6, 7, 0, 0, 0, 0);
    pc_freeze = 1'b1;
    #1;
    n_cmp++; if (fwd_a !== 2'b00) begin n_bad++; $display("FAIL lu_fwd_a got=%b want=00", fwd_a); end
    n_cmp++; if (issue !== 1'b0) begin n_bad++; $display("FAIL lu_issue got=%b want=0", issue); end
    cycle();
    n_cmp++; if (req_vec !== 8'b1000_0000) begin n_bad++; $display("FAIL lu_req got=%b want=10000000", req_vec); end
    pc_freeze = 1'b0;
    #1;
    n_cmp++; if (fwd_a !== 2'b10) begin n_bad++; $display("FAIL mem_fwd_a got=%b want=10", fwd_a); end
    n_cmp++; if (issue !== 1'b1) begin n_bad++; $display("FAIL mem_issue got=%b want=1", issue); end
    cycle();
    n_cmp++; if (req_vec !== 8'b1000_1000) begin n_bad++; $display("FAIL mem_req got=%b want=10001000", req_vec); end
    idle(); cycle(); cycle();
  endtask

  task automatic test_store();
    set_id(1, 0, 0, 3, 0, 0, 0, 0);
    cycle();
    set_id(1, 0, 3, 0, 0, 1, 0, 0);
    #1;
    n_cmp++; if (fwd_b !== 2'b01) begin n_bad++; $display("FAIL st_fwd_b got=%b want=01", fwd_b); end
    cycle();
    n_cmp++; if (req_vec !== 8'b1000_1000) begin n_bad++; $display("FAIL st_fwd_req got=%b want=10001000", req_vec); end
    idle(); cycle(); cycle();
    set_id(1, 0, 0, 3, 1, 0, 0, 0);
    cycle();
    set_id(1, 0, 3, 0, 0, 1, 0, 0);
    #1;
    n_cmp++; if (fwd_b !== 2'b00) begin n_bad++; $display("FAIL st_lu_fwd_b got=%b want=00", fwd_b); end
    cycle();
    n_cmp++; if (req_vec !== 8'b0100_0000) begin n_bad++; $display("FAIL st_lu_req got=%b want=01000000", req_vec); end
    idle(); cycle(); cycle();
  endtask

  task automatic test_branch();
    for (int t = 0; t < 2; t++) begin
      set_id(1, 0, 0, 0, 0, 0, 1, 1);
      cycle();
      set_id(1, 0, 0, 9, 0, 0, 0, 0);
      ex_br_taken = t[0];
      do_flush = 1'b1;
      #1;
      n_cmp++; if (issue !== 1'b0) begin n_bad++; $display("FAIL br_flush_issue t=%0d got=%b want=0", t, issue); end
      cycle();
      n_cmp++; if (req_vec !== ((t == 1) ? 8'b0001_0100 : 8'b0001_0000))
        begin n_bad++; $display("FAIL br_req t=%0d got=%b", t, req_vec); end
      do_flush = 1'b0; ex_br_taken = 1'b0; idle();
      cycle();
      n_cmp++; if (req_vec !== 8'h00) begin n_bad++; $display("FAIL br_after_flush t=%0d got=%b want=00000000", t, req_vec); end
      cycle();
    end
  endtask

  task automatic test_r0();
    set_id(1, 0, 0, 0, 1, 0, 0, 0);
    cycle();
    set_id(1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    n_cmp++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin n_bad++; $display("FAIL r0_fwd got=%b%b want=0000", fwd_a, fwd_b); end
    cycle();
    n_cmp++; if (req_vec !== 8'h00) begin n_bad++; $display("FAIL r0_req got=%b want=00000000", req_vec); end
    #1;
    n_cmp++; if (fwd_a !== 2'b00) begin n_bad++; $display("FAIL r0_mem_fwd_a got=%b want=00", fwd_a); end
    idle(); cycle(); cycle();
  endtask

  task automatic test_watchdog();
    pc_freeze = 1'b1; resolved = 1'b0;
    repeat (10) cycle();
    resolved = 1'b1;
    cycle();
    resolved = 1'b0;
    repeat (14) cycle();
    n_cmp++; if (stall_err !== 1'b0) begin n_bad++; $display("FAIL wd_14 got=%b want=0", stall_err); end
    cycle();
    n_cmp++; if (stall_err !== 1'b1) begin n_bad++; $display("FAIL wd_15 got=%b want=1", stall_err); end
    pc_freeze = 1'b0;
    cycle();
    n_cmp++; if (stall_err !== 1'b1) begin n_bad++; $display("FAIL wd_sticky got=%b want=1", stall_err); end
    set_id(1, 0, 0, 5, 1, 0, 0, 0);
    cycle();
    set_id(1, 5, 5, 0, 0, 0, 0, 0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n_cmp++; if (req_vec !== 8'h00) begin n_bad++; $display("FAIL mid_rst_req got=%b want=00000000", req_vec); end
    n_cmp++; if (stall_err !== 1'b0) begin n_bad++; $display("FAIL mid_rst_err got=%b want=0", stall_err); end
    #1;
    n_cmp++; if (fwd_a !== 2'b00) begin n_bad++; $display("FAIL mid_rst_fwd_a got=%b want=00", fwd_a); end
    idle(); cycle(); cycle();
  endtask

  task automatic test_random();
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int i = 0; i < 600; i++) begin
      set_id($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
      ex_br_taken = ($urandom_range(0, 1) == 1);
      pc_freeze   = ($urandom_range(0, 4) == 0);
      do_flush    = ($urandom_range(0, 7) == 0);
      resolved    = ($urandom_range(0, 1) == 1);
      rst         = ($urandom_range(0, 99) == 0);
      #1;
      model_eval();
      n_cmp++; if (fwd_a !== m_fa) begin n_bad++; $display("FAIL rnd_fwd_a i=%0d got=%b want=%b", i, fwd_a, m_fa); end
      n_cmp++; if (fwd_b !== m_fb) begin n_bad++; $display("FAIL rnd_fwd_b i=%0d got=%b want=%b", i, fwd_b, m_fb); end
      n_cmp++; if (issue !== m_iss) begin n_bad++; $display("FAIL rnd_issue i=%0d got=%b want=%b", i, issue, m_iss); end
      cycle();
      n_cmp++; if (req_vec !== exp_req) begin n_bad++; $display("FAIL rnd_req i=%0d got=%b want=%b", i, req_vec, exp_req); end
      n_cmp++; if (stall_err !== exp_err) begin n_bad++; $display("FAIL rnd_err i=%0d got=%b want=%b", i, stall_err, exp_err); end
    end
    rst = 1'b0; pc_freeze = 1'b0; do_flush = 1'b0; idle();
  endtask

  initial begin
    pipe[0] = '{default: 0};
    pipe[1] = '{default: 0};
    test_reset();
    test_load_use();
    test_store();
    test_branch();
    test_r0();
    test_watchdog();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
